// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader: state encoding, widths, bytes per word.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package prog_loader_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 18;
    localparam int BYTES_PER_WORD = 3;

    // CHK only exists when the trailing checksum byte is part of the protocol.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_B0    = 3'd1,
        ST_B1    = 3'd2,
        ST_B2    = 3'd3,
        ST_WRITE = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK   = 3'd5,
`endif
        ST_FIN   = 3'd6
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Loader bus: load command, byte stream in (valid/ready), program memory write port, status.
// Latency: n/a (wiring only).
// Backpressure: rx_ready from the loader side throttles the byte source.
interface prog_loader_if #(
    parameter int ADDR_W = prog_loader_pkg::ADDR_W_DEF,
    parameter int DATA_W = prog_loader_pkg::DATA_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, base_addr, len, rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  start, base_addr, len, rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Shifts bytes in big-endian order; word_o is the word formed by the two held bytes plus byte_i.
// Latency: word_o is combinational on byte_i, so the third byte completes the word in its own cycle.
// Backpressure: none; the caller only asserts shift_en on accepted bytes.
module byte_packer #(
    parameter int DATA_W = prog_loader_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o
);
    logic [15:0] sr_q, sr_d;

    // Keep the two most recent bytes; clear discards any partial word.
    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (shift_en) begin
            sr_d = {sr_q[7:0], byte_i};
        end
    end

    // Byte history register.
    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    // Upper bits of the oldest byte fall off the top of the instruction word.
    assign word_o = DATA_W'({sr_q, byte_i});
endmodule

// File: rtl/prog_loader.sv
// Loads LEN 3-byte words from a byte stream into program memory at BASE_ADDR upward (wrapping).
// Latency: write strobe the cycle after the third byte of a word; DONE/ERR one cycle after the last write.
// Backpressure: rx_ready only in byte-collect states; optional checksum byte via PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t ST_LAST = ST_CHK;
`else
    localparam state_t ST_LAST = ST_FIN;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   cnt_nxt;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rx_ready_q, rx_ready_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic              data_take;
    logic [DATA_W-1:0] packed_word;

    assign accept    = bus.rx_valid & rx_ready_q;
    assign data_take = accept & (state_q inside {ST_B0, ST_B1, ST_B2});
    assign cnt_nxt   = cnt_q + 1'b1;

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q == ST_IDLE),
        .shift_en (data_take),
        .byte_i   (bus.rx_data),
        .word_o   (packed_word)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Running mod-256 sum of the data bytes of the current load.
    always_comb begin
        sum_d = sum_q;
        if (state_q == ST_IDLE) sum_d = '0;
        else if (data_take)     sum_d = sum_q + bus.rx_data;
    end

    // Checksum accumulator.
    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end
`endif

    // Next state, datapath updates and registered output values.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        state_d = ST_FIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_B0;
                        addr_d  = bus.base_addr;
                        len_d   = bus.len;
                        cnt_d   = '0;
                    end
                end
            end
            ST_B0: if (accept) state_d = ST_B1;
            ST_B1: if (accept) state_d = ST_B2;
            ST_B2: begin
                if (accept) begin
                    state_d   = ST_WRITE;
                    wr_addr_d = addr_q;
                    wr_data_d = packed_word;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_nxt;
                state_d = (cnt_nxt == len_q) ? ST_LAST : ST_B0;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_d = ST_FIN;
                    err_d   = (bus.rx_data != sum_q);
                end
            end
`endif
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

`ifdef PROG_LOADER_CHECKSUM_EN
        rx_ready_d = state_d inside {ST_B0, ST_B1, ST_B2, ST_CHK};
`else
        rx_ready_d = state_d inside {ST_B0, ST_B1, ST_B2};
`endif
        wr_en_d = (state_d == ST_WRITE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FIN);
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rx_ready_q <= rx_ready_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: expected writes/status derived from a load description, checked every cycle.
// Latency: n/a.
// Backpressure: byte source honours rx_ready with constant, toggling and random rx_valid.
module tb_prog_loader;
    localparam int AW = 10;
    localparam int DW = 18;
    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   len_t;
    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) pif ();
    prog_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(pif));

    int          n_chk = 0;
    int          n_fail = 0;
    wr_t         exp_wq[$];
    wr_t         cap_q[$];
    logic        exp_err_q[$];
    logic [7:0]  stim_q[$];
    int          done_cnt = 0;
    int          busy_cyc = 0;
    logic        last_done_err = 1'b0;
    addr_t       last_addr = '0;
    logic [DW-1:0] last_data = '0;
    wr_t         mon_w, exp_w;
    logic        exp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the queued expectations.
    always @(negedge clk) begin
        if (rst) begin
            last_addr = '0;
            last_data = '0;
        end else begin
            if (pif.busy) busy_cyc++;
            if (pif.wr_en) begin
                mon_w.addr = pif.wr_addr;
                mon_w.data = pif.wr_data;
                cap_q.push_back(mon_w);
                if (exp_wq.size() == 0) begin
                    check("spurious_wr_en", 32'(pif.wr_en), 32'd0);
                end else begin
                    exp_w = exp_wq.pop_front();
                    check("wr_addr", 32'(pif.wr_addr), 32'(exp_w.addr));
                    check("wr_data", 32'(pif.wr_data), 32'(exp_w.data));
                end
                last_addr = pif.wr_addr;
                last_data = pif.wr_data;
            end else begin
                check("wr_addr_hold", 32'(pif.wr_addr), 32'(last_addr));
                check("wr_data_hold", 32'(pif.wr_data), 32'(last_data));
            end
            if (pif.done) begin
                done_cnt++;
                last_done_err = pif.err;
                if (exp_err_q.size() == 0) begin
                    check("spurious_done", 32'(pif.done), 32'd0);
                end else begin
                    exp_e = exp_err_q.pop_front();
                    check("err_at_done", 32'(pif.err), 32'(exp_e));
                    check("writes_left_at_done", 32'(exp_wq.size()), 32'd0);
                end
            end
            check("err_only_with_done", 32'(pif.err & ~pif.done), 32'd0);
            check("rx_ready_only_busy", 32'(pif.rx_ready & ~pif.busy), 32'd0);
        end
    end

    task automatic push3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        stim_q.push_back(b0);
        stim_q.push_back(b1);
        stim_q.push_back(b2);
    endtask

    task automatic push_rand(input int nwords);
        for (int i = 0; i < nwords; i++) push3(8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // mode: 0 constant valid, 1 toggling valid, 2 random valid plus stray start/len/base noise.
    // abort_after >= 0: assert reset once that many bytes have been accepted.
    task automatic run_load(input int base, input int len, input int mode, input bit bad_chk,
                            input int abort_after);
        int nbytes, idx, cyc;
        bit xfer, v, exp_err;
        logic [7:0] sum;
        wr_t w;
        sum = 8'd0;
        for (int i = 0; i < stim_q.size(); i++) sum = sum + stim_q[i];
        nbytes = 3 * len;
        if (abort_after < 0) begin
            for (int i = 0; i < len; i++) begin
                w.addr = addr_t'((base + i) % (1 << AW));
                w.data = {stim_q[3*i][1:0], stim_q[3*i+1], stim_q[3*i+2]};
                exp_wq.push_back(w);
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (len > 0) begin
            stim_q.push_back(bad_chk ? sum + 8'd1 : sum);
            nbytes++;
        end
        exp_err = (len == 0) || bad_chk;
`else
        exp_err = (len == 0);
`endif
        if (abort_after < 0) exp_err_q.push_back(exp_err);

        @(posedge clk); #1;
        pif.start     = 1'b1;
        pif.base_addr = addr_t'(base);
        pif.len       = len_t'(len);
        pif.rx_valid  = 1'b0;
        @(posedge clk); #1;
        pif.start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < nbytes && cyc < 8000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            pif.rx_valid  = v;
            pif.rx_data   = v ? stim_q[idx] : 8'($urandom);
            pif.base_addr = addr_t'($urandom);
            pif.len       = len_t'($urandom);
            if (mode == 2) pif.start = 1'($urandom_range(0, 1));
            @(negedge clk);
            xfer = pif.rx_valid && pif.rx_ready;
            @(posedge clk); #1;
            pif.start = 1'b0;
            cyc++;
            if (xfer) begin
                idx++;
                if (idx == abort_after) begin
                    pif.rx_valid = 1'b0;
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    @(negedge clk);
                    check("abort_busy", 32'(pif.busy), 32'd0);
                    check("abort_rx_ready", 32'(pif.rx_ready), 32'd0);
                    check("abort_wr_en", 32'(pif.wr_en), 32'd0);
                    check("abort_done", 32'(pif.done), 32'd0);
                    check("abort_wr_addr", 32'(pif.wr_addr), 32'd0);
                    check("abort_wr_data", 32'(pif.wr_data), 32'd0);
                    stim_q.delete();
                    return;
                end
            end
        end
        pif.rx_valid = 1'b0;
        pif.start    = 1'b0;
        check("bytes_consumed", 32'(idx), 32'(nbytes));
        cyc = 0;
        while (exp_err_q.size() > 0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", 32'(exp_err_q.size()), 32'd0);
        @(posedge clk); #1;
        stim_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, b0, len, base, mode;
        pif.start     = 1'b0;
        pif.base_addr = '0;
        pif.len       = '0;
        pif.rx_data   = '0;
        pif.rx_valid  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", 32'(pif.rx_ready), 32'd0);
        check("rst_wr_en", 32'(pif.wr_en), 32'd0);
        check("rst_busy", 32'(pif.busy), 32'd0);
        check("rst_done", 32'(pif.done), 32'd0);
        check("rst_err", 32'(pif.err), 32'd0);
        check("rst_wr_addr", 32'(pif.wr_addr), 32'd0);
        check("rst_wr_data", 32'(pif.wr_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two words from base 0 with constant valid.
        cap_q.delete();
        d0 = done_cnt;
        push3(8'h03, 8'hFF, 8'hFF);
        push3(8'h00, 8'h12, 8'h34);
        run_load(0, 2, 0, 1'b0, -1);
        check("t1_nwrites", 32'(cap_q.size()), 32'd2);
        if (cap_q.size() >= 2) begin
            check("t1_w0_data", 32'(cap_q[0].data), 32'h3FFFF);
            check("t1_w0_addr", 32'(cap_q[0].addr), 32'd0);
            check("t1_w1_data", 32'(cap_q[1].data), 32'h01234);
            check("t1_w1_addr", 32'(cap_q[1].addr), 32'd1);
        end
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_err", 32'(last_done_err), 32'd0);

        // Address wrap at the top of memory.
        cap_q.delete();
        push_rand(2);
        run_load(1023, 2, 0, 1'b0, -1);
        check("t2_nwrites", 32'(cap_q.size()), 32'd2);
        if (cap_q.size() >= 2) begin
            check("t2_w0_addr", 32'(cap_q[0].addr), 32'd1023);
            check("t2_w1_addr", 32'(cap_q[1].addr), 32'd0);
        end

        // Toggling valid, single word.
        cap_q.delete();
        push3(8'h01, 8'h02, 8'h03);
        run_load(7, 1, 1, 1'b0, -1);
        check("t3_nwrites", 32'(cap_q.size()), 32'd1);
        if (cap_q.size() >= 1) check("t3_w0_data", 32'(cap_q[0].data), 32'h10203);

        // LEN=0 is an immediate error completion.
        cap_q.delete();
        b0 = busy_cyc;
        d0 = done_cnt;
        run_load(3, 0, 0, 1'b0, -1);
        check("t4_busy_cycles", 32'(busy_cyc - b0), 32'd1);
        check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t4_err", 32'(last_done_err), 32'd1);
        check("t4_nwrites", 32'(cap_q.size()), 32'd0);

        // Reset after the second byte of word 0, then a clean load.
        cap_q.delete();
        push_rand(2);
        run_load(5, 2, 0, 1'b0, 2);
        check("t5_abort_nwrites", 32'(cap_q.size()), 32'd0);
        push_rand(3);
        run_load(100, 3, 2, 1'b0, -1);
        check("t5_reload_nwrites", 32'(cap_q.size()), 32'd3);

`ifdef PROG_LOADER_CHECKSUM_EN
        push3(8'h01, 8'h02, 8'h03);
        run_load(0, 1, 0, 1'b0, -1);
        check("t6_good_chk_err", 32'(last_done_err), 32'd0);
        push3(8'h01, 8'h02, 8'h03);
        run_load(0, 1, 0, 1'b1, -1);
        check("t6_bad_chk_err", 32'(last_done_err), 32'd1);
`endif

        // Random loads.
        for (int n = 0; n < 30; n++) begin
            base = int'($urandom_range(0, 1023));
            len  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            mode = int'($urandom_range(0, 2));
            push_rand(len);
            run_load(base, len, mode, 1'($urandom_range(0, 1)), -1);
        end

        // Full-memory load exercises the widest LEN.
        cap_q.delete();
        push_rand(1024);
        run_load(512, 1024, 0, 1'b0, -1);
        check("t8_nwrites", 32'(cap_q.size()), 32'd1024);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10, program memory address width (1024 words).
REQ-002 Parameter DATA_W, default 18, instruction width.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 START  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 BASE_ADDR  input  ADDR_W  first write address; sampled with START.
REQ-007 LEN  input  ADDR_W+1  word count, 0..1024; sampled with START.
REQ-008 RX_DATA  input  8  incoming byte.
REQ-009 RX_VALID  input  1  RX_DATA valid.
REQ-010 RX_READY  output  1  loader accepts a byte this cycle.
REQ-011 WR_EN  output  1  program memory write strobe.
REQ-012 WR_ADDR  output  ADDR_W  write address.
REQ-013 WR_DATA  output  DATA_W  instruction word.
REQ-014 BUSY  output  1  high in all states except IDLE.
REQ-015 DONE  output  1  one-cycle pulse on load completion.
REQ-016 ERR  output  1  one-cycle pulse, coincident with DONE, on failed load.

Function
REQ-017 Byte transfer occurs only on a cycle with RX_VALID=1 and RX_READY=1; RX_VALID without RX_READY is held off, and no byte is lost or duplicated.
REQ-018 States: IDLE, B0, B1, B2, WRITE, CHK (macro only), FIN.
REQ-019 IDLE + START: LEN=0 -> FIN with ERR; LEN>0 -> B0, and BASE_ADDR, LEN and word counter (=0) are latched.
REQ-020 B0/B1/B2: RX_READY=1; each accepted byte advances to the next state; RX_READY=0 in every other state.
REQ-021 Packing, big-endian: WR_DATA[17:16]=byte0[1:0], [15:8]=byte1, [7:0]=byte2; byte0[7:2] ignored.
REQ-022 WRITE: WR_EN=1 for exactly one cycle, carrying the assembled word and current address; WR_EN=0 in all other states.
REQ-023 After WRITE: address += 1, wrapping from 2^ADDR_W-1 to 0; counter += 1; counter==LEN -> CHK (macro) or FIN, else B0.
REQ-024 Write latency: WR_EN asserts on the cycle after the third byte is accepted.
REQ-025 FIN: DONE=1 (ERR as decided) for one cycle, then IDLE.
REQ-026 START while BUSY is ignored; LEN/BASE_ADDR changes after START have no effect.
REQ-027 WR_ADDR and WR_DATA hold their last values outside WRITE.

Reset
REQ-028 RST=1 at any clock edge -> IDLE, counter=0, WR_ADDR=0, WR_DATA=0, and RX_READY, WR_EN, BUSY, DONE, ERR all 0.
REQ-029 Reset mid-load aborts with no further WR_EN and no DONE; a partially assembled word is discarded.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN defined: an 8-bit running sum (mod 256) of all data bytes is kept; CHK accepts one extra byte (RX_READY=1); mismatch -> ERR with DONE; match -> DONE only.
REQ-031 Macro undefined: no CHK state and no sum register; ERR is raised only for LEN=0.

Structure
REQ-032 Package prog_loader_pkg holds the state enum, ADDR_W/DATA_W defaults, and BYTES_PER_WORD=3.
REQ-033 Sub-module byte_packer (shift-in of 3 bytes to a DATA_W word, with clear) is instantiated once; FSM, counters and checksum stay in prog_loader.

Verification
REQ-034 BASE_ADDR=0, LEN=2, bytes 03 FF FF 00 12 34, RX_VALID constant -> writes 0x3FFFF@0 then 0x01234@1, DONE pulse, ERR=0.
REQ-035 BASE_ADDR=1023, LEN=2 -> writes at 1023 then 0 (wrap).
REQ-036 RX_VALID toggled 1/0 every cycle, LEN=1, bytes 01 02 03 -> single write 0x10203; no lost or duplicated byte.
REQ-037 LEN=0 + START -> DONE and ERR on the same cycle, no WR_EN, BUSY high exactly 1 cycle.
REQ-038 RST asserted after byte1 of word 0 -> IDLE next cycle, no WR_EN; a new START load completes correctly.
REQ-039 With PROG_LOADER_CHECKSUM_EN, LEN=1, bytes 01 02 03 then checksum 06 -> DONE, ERR=0; checksum 07 -> DONE with ERR=1.
